ingress_arbiter: RTL and testbench
==================================

// Module: ingress_arbiter
// PURPOSE
//   Merges NUM_PHYS_FUNC PF and NUM_CMAC_PORT CMAC axi_stream_if sources into the single
//   axi_stream_vnp4_if stream feeding the VNP4 pipeline, mirror of egress_switch on the RX side.
//   Packet-granular round-robin: a grant holds until the granted source's last beat is taken.
//   Stamps one-hot user_src_pf/user_src_cmac so the pipeline and egress know the packet origin.
// PARAMETERS
//   NUM_PHYS_FUNC  1  number of PF sources, legal 1..4 (user_src_pf width 4)
//   NUM_CMAC_PORT  1  number of CMAC sources, legal 1..10 (user_src_cmac width 10)
// PORTS
//   aclk         in   1      clock; all logic on posedge
//   aresetn      in   1      asynchronous, active-low reset
//   s_axis_pf    slv  [NUM_PHYS_FUNC] axi_stream_if   PF sources (data/keep/last/user_size/user_src/user_dst)
//   s_axis_cmac  slv  [NUM_CMAC_PORT] axi_stream_if   CMAC sources
//   m_axis       mst  axi_stream_vnp4_if               merged stream to pipeline
// BEHAVIOUR
//   - Requester index r: PF i -> r=i; CMAC j -> r=NUM_PHYS_FUNC+j; N=NUM_PHYS_FUNC+NUM_CMAC_PORT.
//   - Reset: state=IDLE, last_grant=N-1 (port 0 wins first), buff_valid=0, m_axis.valid=0,
//     m_axis.user_valid=0, all s_axis*.ready=0. Reset mid-packet drops buffered beat; no flush.
//   - FSM IDLE: if any source valid, pick first valid r after last_grant (wrapping mod N);
//     register grant=r, go BUSY next cycle. No source valid -> stay IDLE. One-cycle arbitration
//     bubble between packets is accepted behaviour.
//   - FSM BUSY: only granted source sees ready = !buff_valid || m_axis.ready; all others ready=0.
//     Beat accepted when granted valid && ready -> captured into single-entry output buffer.
//     Accepted beat with last=1 -> last_grant<=grant, state IDLE same edge.
//     Granted source deasserting valid mid-packet: stay BUSY, grant held (no timeout).
//   - Output buffer: buff_valid set on capture, cleared on m_axis.valid && m_axis.ready with no
//     simultaneous capture; simultaneous drain+capture keeps buff_valid=1 with new beat (full rate).
//     While valid && !ready all m_axis fields held stable.
//   - Latency: source valid in IDLE at cycle N -> ready at N+1 -> m_axis.valid at N+2.
//     Steady-state throughput in BUSY: 1 beat/cycle when m_axis.ready=1.
//   - m_axis fields: data/keep/last/user_size copied; user_valid = buff_valid;
//     user_src_pf = 1<<i for PF i else 0; user_src_cmac = 1<<j for CMAC j else 0;
//     user_dst_pf=0, user_dst_cmac=0, user_to_direction=0 (pipeline resolves destination).
//   - Source-side user_src/user_dst inputs ignored.
//   - Simultaneous requests: strict round-robin order; a source keeping valid high is served
//     at most once per N packets while others request (no starvation).
// STRUCTURE
//   - direction_pkg: add localparam PF_SEL_W=4, CMAC_SEL_W=10 and function src_onehot(r) returning
//     {cmac_onehot, pf_onehot}; shared with egress_switch widths.
//   - Sub-module rr_arbiter #(N): inputs req[N], last_grant; output grant index + any_req.
//     Pure combinational rotate-priority; FSM, buffer and muxing stay in ingress_arbiter.
//   - Source muxing via generate loops over PF/CMAC interface arrays into packed vectors.
// TESTING
//   1 Single PF0 3-beat packet, m_axis.ready=1 -> beats at cycles N+2..N+4, user_src_pf=4'b0001, last on beat 3.
//   2 PF0,PF1,CMAC0 (N=3 with PF=2,CMAC=1) all valid at reset release, 1-beat pkts -> order PF0,PF1,CMAC0,PF0.
//   3 CMAC1 4-beat pkt, m_axis.ready toggles 1010 -> no beat lost/duplicated, fields stable while stalled.
//   4 PF0 mid-packet valid gap of 5 cycles while PF1 valid -> PF1 ready stays 0 until PF0 last accepted.
//   5 aresetn low mid-packet (beat 2 of 4) -> m_axis.valid=0 next cycle; after release arbitration restarts at PF0.
//   6 Back-to-back 64-beat pkts on one source, ready=1 -> 1 bubble between pkts, 64 beats/pkt contiguous.

Source files
------------

// File: rtl/ingress_arbiter_pkg.sv
// Shared types for the RX ingress merge: source beat, VNP4 pipeline beat, FSM states
// and the origin one-hot helper used to stamp user_src_pf/user_src_cmac.
package ingress_arbiter_pkg;

    localparam int PF_SEL_W   = 4;
    localparam int CMAC_SEL_W = 10;
    localparam int SRC_IDX_W  = 4;
    localparam int DATA_W     = 64;
    localparam int KEEP_W     = DATA_W / 8;
    localparam int SIZE_W     = 16;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } arb_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic [SIZE_W-1:0] user_size;
    } axis_beat_t;

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [KEEP_W-1:0]     keep;
        logic                  last;
        logic [SIZE_W-1:0]     user_size;
        logic                  user_valid;
        logic [PF_SEL_W-1:0]   user_src_pf;
        logic [CMAC_SEL_W-1:0] user_src_cmac;
        logic [PF_SEL_W-1:0]   user_dst_pf;
        logic [CMAC_SEL_W-1:0] user_dst_cmac;
        logic                  user_to_direction;
    } vnp4_beat_t;

    // Requesters 0..num_pf-1 are PFs, the rest are CMAC ports.
    function automatic logic [CMAC_SEL_W+PF_SEL_W-1:0] src_onehot(
        input logic [SRC_IDX_W-1:0] r,
        input logic [SRC_IDX_W-1:0] num_pf
    );
        logic [PF_SEL_W-1:0]   pf;
        logic [CMAC_SEL_W-1:0] cm;
        pf = '0;
        cm = '0;
        if (r < num_pf)
            pf = PF_SEL_W'(1) << r;
        else
            cm = CMAC_SEL_W'(1) << (r - num_pf);
        return {cm, pf};
    endfunction

endpackage

// File: rtl/ingress_arbiter_rr.sv
// Combinational rotate-priority pick: first requester after last_grant, wrapping mod N.
// Zero latency; holds no state, so backpressure is the caller's concern.
module ingress_arbiter_rr #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [$clog2(N)-1:0] grant,
    output logic                 any_req
);
    localparam int IW = $clog2(N);

    logic [IW:0] cand;
    logic        found;

    always_comb begin
        grant = last_grant;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, last_grant} + (IW+1)'(k);
            if (cand >= (IW+1)'(N))
                cand = cand - (IW+1)'(N);
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                grant = cand[IW-1:0];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/ingress_arbiter.sv
// Packet-granular round-robin merge of PF and CMAC sources into one VNP4 stream; valid->out in 2 cycles.
// Only the granted source sees ready (buffer empty or draining); grant held until its last beat is taken.
module ingress_arbiter
    import ingress_arbiter_pkg::*;
#(
    parameter int NUM_PHYS_FUNC = 1,
    parameter int NUM_CMAC_PORT = 1
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic       [NUM_PHYS_FUNC-1:0]   s_axis_pf_valid,
    output logic       [NUM_PHYS_FUNC-1:0]   s_axis_pf_ready,
    input  axis_beat_t [NUM_PHYS_FUNC-1:0]   s_axis_pf_beat,
    input  logic       [NUM_CMAC_PORT-1:0]   s_axis_cmac_valid,
    output logic       [NUM_CMAC_PORT-1:0]   s_axis_cmac_ready,
    input  axis_beat_t [NUM_CMAC_PORT-1:0]   s_axis_cmac_beat,
    output logic                             m_axis_valid,
    input  logic                             m_axis_ready,
    output vnp4_beat_t                       m_axis_beat
);
    localparam int N  = NUM_PHYS_FUNC + NUM_CMAC_PORT;
    localparam int IW = $clog2(N);

    logic [N-1:0] src_valid;
    logic [N-1:0] src_ready;
    axis_beat_t   src_beat [N];

    for (genvar i = 0; i < NUM_PHYS_FUNC; i++) begin : g_pf
        assign src_valid[i] = s_axis_pf_valid[i];
        assign src_beat[i]  = s_axis_pf_beat[i];
    end
    for (genvar j = 0; j < NUM_CMAC_PORT; j++) begin : g_cmac
        assign src_valid[NUM_PHYS_FUNC+j] = s_axis_cmac_valid[j];
        assign src_beat[NUM_PHYS_FUNC+j]  = s_axis_cmac_beat[j];
    end

    arb_state_t state;
    logic [IW-1:0] grant, last_grant, arb_grant;
    logic          any_req, take, accept;
    logic          buff_valid;
    axis_beat_t    buff_beat;
    logic [CMAC_SEL_W+PF_SEL_W-1:0] buff_src;

    ingress_arbiter_rr #(.N(N)) u_rr (
        .req        (src_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any_req    (any_req)
    );

    // Ready may assert while the buffer drains in the same cycle, giving full rate.
    assign take      = (state == ST_BUSY) && (!buff_valid || m_axis_ready);
    assign accept    = take && src_valid[grant];
    assign src_ready = take ? (N'(1) << grant) : '0;

    assign s_axis_pf_ready   = src_ready[NUM_PHYS_FUNC-1:0];
    assign s_axis_cmac_ready = src_ready[N-1:NUM_PHYS_FUNC];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= IW'(N-1);
            buff_valid <= 1'b0;
            buff_beat  <= '0;
            buff_src   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (any_req) begin
                    grant <= arb_grant;
                    state <= ST_BUSY;
                end
                ST_BUSY: if (accept && src_beat[grant].last) begin
                    last_grant <= grant;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (accept) begin
                buff_valid <= 1'b1;
                buff_beat  <= src_beat[grant];
                buff_src   <= src_onehot(SRC_IDX_W'(grant), SRC_IDX_W'(NUM_PHYS_FUNC));
            end else if (m_axis_ready) begin
                buff_valid <= 1'b0;
            end
        end
    end

    // Destination fields stay zero: the pipeline resolves where the packet goes.
    always_comb begin
        m_axis_beat               = '0;
        m_axis_beat.data          = buff_beat.data;
        m_axis_beat.keep          = buff_beat.keep;
        m_axis_beat.last          = buff_beat.last;
        m_axis_beat.user_size     = buff_beat.user_size;
        m_axis_beat.user_valid    = buff_valid;
        m_axis_beat.user_src_pf   = buff_src[PF_SEL_W-1:0];
        m_axis_beat.user_src_cmac = buff_src[PF_SEL_W +: CMAC_SEL_W];
    end

    assign m_axis_valid = buff_valid;

endmodule

// File: tb/tb_ingress_arbiter.sv
// Directed bench for ingress_arbiter with 2 PF + 2 CMAC sources (requesters 0..3).
module tb_ingress_arbiter;
    import ingress_arbiter_pkg::*;

    logic aclk = 1'b0;
    logic aresetn;
    logic       [1:0] pf_valid, pf_ready, cm_valid, cm_ready;
    axis_beat_t [1:0] pf_beat, cm_beat;
    logic             m_valid;
    logic             m_ready;
    vnp4_beat_t       m_beat;

    logic       src_vld [4];
    axis_beat_t src_dat [4];
    logic [3:0] src_rdy;

    assign pf_valid = {src_vld[1], src_vld[0]};
    assign cm_valid = {src_vld[3], src_vld[2]};
    assign pf_beat  = {src_dat[1], src_dat[0]};
    assign cm_beat  = {src_dat[3], src_dat[2]};
    assign src_rdy  = {cm_ready, pf_ready};

    ingress_arbiter #(.NUM_PHYS_FUNC(2), .NUM_CMAC_PORT(2)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .s_axis_pf_valid   (pf_valid),
        .s_axis_pf_ready   (pf_ready),
        .s_axis_pf_beat    (pf_beat),
        .s_axis_cmac_valid (cm_valid),
        .s_axis_cmac_ready (cm_ready),
        .s_axis_cmac_beat  (cm_beat),
        .m_axis_valid      (m_valid),
        .m_axis_ready      (m_ready),
        .m_axis_beat       (m_beat)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    vnp4_beat_t rx_beat [$];
    int         rx_cyc  [$];
    logic       hold_pend = 1'b0;
    vnp4_beat_t held;

    // Output capture plus stability of every field while stalled.
    always @(negedge aclk) begin
        if (m_valid && m_ready) begin
            rx_beat.push_back(m_beat);
            rx_cyc.push_back(cyc);
        end
        if (hold_pend && m_valid)
            check("stall_hold", 128'(m_beat), 128'(held));
        hold_pend = aresetn && m_valid && !m_ready;
        held      = m_beat;
    end

    function automatic axis_beat_t mk_beat(input int r, input int pkt, input int b, input logic lst);
        axis_beat_t x;
        x.data      = {40'h0, 8'(r), 8'(pkt), 8'(b)};
        x.keep      = 8'hFF;
        x.last      = lst;
        x.user_size = 16'(pkt * 16 + b);
        return x;
    endfunction

    task automatic check_beat(input string tag, input int idx, input int r, input int pkt,
                              input int b, input logic lst);
        axis_beat_t e  = mk_beat(r, pkt, b, lst);
        vnp4_beat_t bt = rx_beat[idx];
        logic [3:0] epf = (r < 2)  ? 4'(1 << r) : 4'd0;
        logic [9:0] ecm = (r >= 2) ? 10'(1 << (r - 2)) : 10'd0;
        check({tag, "_data"}, 128'(bt.data), 128'(e.data));
        check({tag, "_last"}, 128'(bt.last), 128'(e.last));
        check({tag, "_size"}, 128'(bt.user_size), 128'(e.user_size));
        check({tag, "_uvld"}, 128'(bt.user_valid), 128'(1'b1));
        check({tag, "_srcpf"}, 128'(bt.user_src_pf), 128'(epf));
        check({tag, "_srccm"}, 128'(bt.user_src_cmac), 128'(ecm));
        check({tag, "_dst"}, 128'({bt.user_dst_pf, bt.user_dst_cmac, bt.user_to_direction}), 128'(0));
    endtask

    task automatic wait_hs(input int r);
        logic got = 1'b0;
        for (int t = 0; t < 500 && !got; t++) begin
            @(negedge aclk);
            if (src_rdy[r]) got = 1'b1;
        end
        @(posedge aclk);
        #1;
        check("handshake", 128'(got), 128'(1'b1));
    endtask

    task automatic send_pkts(input int r, input int npkts, input int nbeats, input int pkt_base,
                             input int gap_after, input int gap_len);
        for (int p = 0; p < npkts; p++) begin
            for (int b = 0; b < nbeats; b++) begin
                src_dat[r] = mk_beat(r, pkt_base + p, b, b == nbeats - 1);
                src_vld[r] = 1'b1;
                wait_hs(r);
                if (b == gap_after) begin
                    src_vld[r] = 1'b0;
                    repeat (gap_len) @(posedge aclk);
                    #1;
                end
            end
        end
        src_vld[r] = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic clear_rx();
        rx_beat.delete();
        rx_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int viol;
        int pf0_done;
        int t3_done;

        aresetn = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_vld[i] = 1'b1;
            src_dat[i] = mk_beat(i, 0, 0, 1'b1);
        end
        @(negedge aclk);
        check("rst_m_valid", 128'(m_valid), 128'(0));
        check("rst_user_valid", 128'(m_beat.user_valid), 128'(0));
        check("rst_pf_ready", 128'(pf_ready), 128'(0));
        check("rst_cm_ready", 128'(cm_ready), 128'(0));
        for (int i = 0; i < 4; i++) src_vld[i] = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        settle();

        // 1: single PF0 3-beat packet, beats at start+2..start+4
        clear_rx();
        start = cyc;
        send_pkts(0, 1, 3, 1, -1, 0);
        settle();
        check("t1_count", 128'(rx_beat.size()), 128'(3));
        for (int i = 0; i < 3 && i < rx_beat.size(); i++) begin
            check_beat("t1", i, 0, 1, i, i == 2);
            check("t1_cycle", 128'(rx_cyc[i]), 128'(start + 2 + i));
        end

        // 2: PF0, PF1, CMAC0 valid across reset release -> PF0, PF1, CMAC0, PF0
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        clear_rx();
        fork
            send_pkts(0, 2, 1, 20, -1, 0);
            send_pkts(1, 1, 1, 20, -1, 0);
            send_pkts(2, 1, 1, 20, -1, 0);
            begin
                repeat (2) @(posedge aclk);
                #1;
                aresetn = 1'b1;
            end
        join
        settle();
        check("t2_count", 128'(rx_beat.size()), 128'(4));
        if (rx_beat.size() == 4) begin
            check_beat("t2_0", 0, 0, 20, 0, 1'b1);
            check_beat("t2_1", 1, 1, 20, 0, 1'b1);
            check_beat("t2_2", 2, 2, 20, 0, 1'b1);
            check_beat("t2_3", 3, 0, 21, 0, 1'b1);
        end

        // 3: CMAC1 4-beat packet under toggling m_axis_ready
        clear_rx();
        t3_done = 0;
        fork
            begin
                send_pkts(3, 1, 4, 30, -1, 0);
                t3_done = 1;
            end
            for (int t = 0; t < 300 && t3_done == 0; t++) begin
                m_ready = ~m_ready;
                @(posedge aclk);
                #1;
            end
        join
        m_ready = 1'b1;
        settle();
        check("t3_count", 128'(rx_beat.size()), 128'(4));
        for (int i = 0; i < 4 && i < rx_beat.size(); i++)
            check_beat("t3", i, 3, 30, i, i == 3);

        // 4: PF0 stalls mid-packet for 5 cycles; PF1 must not be readied meanwhile
        clear_rx();
        pf0_done = 0;
        viol = 0;
        fork
            begin
                send_pkts(0, 1, 4, 40, 1, 5);
                pf0_done = 1;
            end
            send_pkts(1, 1, 1, 40, -1, 0);
            for (int t = 0; t < 300 && pf0_done == 0; t++) begin
                @(negedge aclk);
                if (pf_ready[1]) viol++;
            end
        join
        settle();
        check("t4_pf1_ready_early", 128'(viol), 128'(0));
        check("t4_count", 128'(rx_beat.size()), 128'(5));
        if (rx_beat.size() == 5) begin
            for (int i = 0; i < 4; i++)
                check_beat("t4_pf0", i, 0, 40, i, i == 3);
            check_beat("t4_pf1", 4, 1, 40, 0, 1'b1);
        end

        // 5: reset while beat 2 of 4 sits in the buffer; arbitration restarts at PF0
        clear_rx();
        src_dat[0] = mk_beat(0, 50, 0, 1'b0);
        src_vld[0] = 1'b1;
        wait_hs(0);
        src_dat[0] = mk_beat(0, 50, 1, 1'b0);
        wait_hs(0);
        aresetn = 1'b0;
        src_vld[0] = 1'b0;
        @(negedge aclk);
        check("t5_m_valid", 128'(m_valid), 128'(0));
        check("t5_user_valid", 128'(m_beat.user_valid), 128'(0));
        check("t5_ready", 128'({cm_ready, pf_ready}), 128'(0));
        check("t5_pre_count", 128'(rx_beat.size()), 128'(1));
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        settle();
        clear_rx();
        fork
            send_pkts(1, 1, 1, 51, -1, 0);
            send_pkts(2, 1, 1, 51, -1, 0);
            send_pkts(0, 1, 1, 51, -1, 0);
        join
        settle();
        check("t5_count", 128'(rx_beat.size()), 128'(3));
        if (rx_beat.size() == 3) begin
            check_beat("t5_0", 0, 0, 51, 0, 1'b1);
            check_beat("t5_1", 1, 1, 51, 0, 1'b1);
            check_beat("t5_2", 2, 2, 51, 0, 1'b1);
        end

        // 6: two back-to-back 64-beat packets on CMAC0: contiguous, one bubble between
        clear_rx();
        send_pkts(2, 2, 64, 60, -1, 0);
        settle();
        check("t6_count", 128'(rx_beat.size()), 128'(128));
        if (rx_beat.size() == 128) begin
            for (int i = 0; i < 128; i++) begin
                check("t6_data", 128'(rx_beat[i].data), 128'(mk_beat(2, 60 + i / 64, i % 64, 1'b0).data));
                check("t6_last", 128'(rx_beat[i].last), 128'((i % 64) == 63));
                if (i > 0)
                    check("t6_spacing", 128'(rx_cyc[i] - rx_cyc[i-1]), 128'((i == 64) ? 2 : 1));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
